mux_rr_arbiter: RTL

Round-robin arbiter that shares the team's 8:1 single-bit multiplexer (8-bit `data`, 3-bit `sel`, output `Y`) among eight requesters. Requester *i* owns input `data[i]`. The block picks one requester, drives the mux select for it, and registers the selected bit as a valid stream. It also enforces a maximum hold time so that no requester can starve the others. It sits between the requester logic and the existing mux datapath, and its `sel` output feeds the mux select directly.

---
 rtl/mux_rr_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter in front of the shared 8:1 single-bit mux.
// Picks one requester, drives the mux select for it, registers data[sel]
// as a valid stream and forces a release after MAX_HOLD cycles when others wait.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no grant held; next edge arbitrates among req from ptr
// ST_GRANT| grant held by sel; Y streams data[sel] one cycle later
module mux_rr_arbiter #(
  parameter int N        = 8,
  parameter int SEL_W    = 3,
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     data,
  output logic [SEL_W-1:0] sel,
  output logic [N-1:0]     gnt,
  output logic             busy,
  output logic             Y,
  output logic             valid
);

  typedef enum logic {ST_IDLE, ST_GRANT} state_t;

  // hold_cnt saturates at 255, so the compare still fires once the limit is passed
  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD - 1);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [7:0]       hold_cnt_q, hold_cnt_d;
  logic             busy_q, busy_d;
  logic             y_q, y_d;
  logic             valid_q, valid_d;

  logic [SEL_W-1:0] win_idx;
  logic [SEL_W-1:0] scan_idx;
  logic             win_found;
  logic             release_now;

  // Rotating priority scan: first set request at ptr, ptr+1, ... (mod N)
  always_comb begin
    win_idx   = ptr_q;
    win_found = 1'b0;
    scan_idx  = ptr_q;
    for (int i = 0; i < N; i++) begin
      scan_idx = ptr_q + SEL_W'(i);
      if (!win_found && req[scan_idx]) begin
        win_idx   = scan_idx;
        win_found = 1'b1;
      end
    end
  end

  // Release when the grantee drops its request or it has used up its turn under contention
  always_comb begin
    release_now = !req[sel_q] || ((hold_cnt_q >= HOLD_LIMIT) && (|(req & ~gnt_q)));
  end

  // Next-state and registered-output computation
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    sel_d      = sel_q;
    gnt_d      = gnt_q;
    hold_cnt_d = hold_cnt_q;
    busy_d     = busy_q;
    y_d        = y_q;
    valid_d    = valid_q;
    case (state_q)
      ST_IDLE: begin
        valid_d = 1'b0;
        if (win_found) begin
          sel_d      = win_idx;
          gnt_d      = N'(1) << win_idx;
          busy_d     = 1'b1;
          hold_cnt_d = 8'd0;
          state_d    = ST_GRANT;
        end
      end
      ST_GRANT: begin
        hold_cnt_d = (hold_cnt_q == 8'hFF) ? hold_cnt_q : hold_cnt_q + 8'd1;
        if (release_now) begin
          // Y keeps its last value and sel keeps pointing at the old grantee
          gnt_d   = '0;
          busy_d  = 1'b0;
          valid_d = 1'b0;
          ptr_d   = sel_q + SEL_W'(1);
          state_d = ST_IDLE;
        end else begin
          y_d     = data[sel_q];
          valid_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      sel_q      <= '0;
      gnt_q      <= '0;
      hold_cnt_q <= 8'd0;
      busy_q     <= 1'b0;
      y_q        <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      sel_q      <= sel_d;
      gnt_q      <= gnt_d;
      hold_cnt_q <= hold_cnt_d;
      busy_q     <= busy_d;
      y_q        <= y_d;
      valid_q    <= valid_d;
    end
  end

  assign sel   = sel_q;
  assign gnt   = gnt_q;
  assign busy  = busy_q;
  assign Y     = y_q;
  assign valid = valid_q;

endmodule
